// File: rtl/cla_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// cla_serial_addsub_ctrl
//
// Purpose:
//   Sequences a W-bit add or subtract (W = 4*NIBBLES) through one shared
//   4-bit carry-lookahead add/sub slice. It handles one nibble per clock,
//   least-significant nibble first. The carry out of each nibble is
//   registered and fed back as the carry-in of the next nibble. Subtract
//   sets slice mode=1, so the slice inverts B, and seeds the first carry-in
//   with 1. Together these form A + ~B + 1.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   start       in   operation request, sampled only in IDLE
//   op_sub      in   0 = A+B, 1 = A-B (latched with start)
//   op_a, op_b  in   W-bit operands (latched with start)
//   busy        out  high while nibbles are being processed (RUN)
//   done        out  one-cycle pulse; result fields valid from this cycle
//   result      out  W-bit sum/difference, held until the next accepted start
//   carry_out   out  final carry; for subtract 1 = no borrow (A >= B)
//   overflow    out  two's-complement overflow of the W-bit operation
//   adder_a/b   out  current operand nibbles to the slice (0 outside RUN)
//   adder_mode  out  slice mode = latched op_sub (0 outside RUN)
//   adder_cin   out  slice carry-in (0 outside RUN)
//   adder_sum   in   slice sum, combinational from adder_* outputs
//   adder_cout  in   slice carry out of bit 3
// ---------------------------------------------------------------------------
module cla_serial_addsub_ctrl #(
    parameter int NIBBLES = 4          // operand width in nibbles, 1..16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic [3:0]             adder_a,
    output logic [3:0]             adder_b,
    output logic                   adder_mode,
    output logic                   adder_cin,
    input  logic [3:0]             adder_sum,
    input  logic                   adder_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;

    // Datapath helpers for the nibble currently in the slice
    logic [IDX_W+1:0]   bit_shift;     // 4*idx, used as a shift amount
    logic [W-1:0]       a_shift;
    logic [W-1:0]       b_shift;
    logic [W-1:0]       nib_mask;
    logic [W-1:0]       sum_placed;
    logic               last_nibble;
    logic               ovf_final;

    // -----------------------------------------------------------------------
    // Nibble selection and result merge
    // -----------------------------------------------------------------------
    always_comb begin
        bit_shift   = {idx_q, 2'b00};
        a_shift     = a_q >> bit_shift;
        b_shift     = b_q >> bit_shift;
        nib_mask    = W'(4'hF) << bit_shift;
        sum_placed  = W'(adder_sum) << bit_shift;
        last_nibble = (idx_q == IDX_W'(NIBBLES - 1));
        // Both forms compare the operand signs as the user sees them. B is
        // un-inverted here. Subtract overflows only when the signs differ.
        // Add overflows only when they match. In both cases the sign of the
        // result must also differ from A.
        ovf_final   = (((a_q[W-1] ^ b_q[W-1]) == sub_q) &&
                       (adder_sum[3] != a_q[W-1]));
    end

    // The slice sees zeros unless this block is actively using it, so it
    // can be shared with other users while we are idle or done.
    always_comb begin
        if (state_q == ST_RUN) begin
            adder_a    = a_shift[3:0];
            adder_b    = b_shift[3:0];
            adder_mode = sub_q;
            adder_cin  = carry_q;
        end else begin
            adder_a    = 4'h0;
            adder_b    = 4'h0;
            adder_mode = 1'b0;
            adder_cin  = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first. A path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d         = op_a;
                    b_d         = op_b;
                    sub_d       = op_sub;
                    idx_d       = '0;
                    carry_d     = op_sub;   // the +1 of two's-complement subtract
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = ST_RUN;
                end
            end

            ST_RUN: begin
                result_d = (result_q & ~nib_mask) | sum_placed;
                carry_d  = adder_cout;
                idx_d    = idx_q + IDX_W'(1);
                if (last_nibble) begin
                    idx_d       = '0;
                    carry_out_d = adder_cout;
                    overflow_d  = ovf_final;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                // Any start seen here is dropped. A caller must re-issue it
                // in a later IDLE cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only. Every register samples its
        // _d value from before this edge, whatever order the lines appear in.
        if (reset) begin
            state_q     <= ST_IDLE;
            // NOTE: the operand registers are reset as well, although only
            // RUN reads them. This keeps unknowns out of the slice inputs and
            // out of equivalence checks after reset.
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/cla_serial_addsub_ctrl.md
Name: cla_serial_addsub_ctrl

Overview:
- Sequencer that performs wide add/subtract using one shared 4-bit carry-lookahead add/sub slice, one nibble per clock, least-significant nibble first.
- Latches operands on a start pulse and drives the slice's a/b/mode/carry-in ports.
- Collects each 4-bit sum and carries carry-out between nibbles.
- Reports the wide result, unsigned carry/borrow and signed overflow, with a start/busy/done handshake.
- Sits between the ALU front-end (operand/opcode source) and the 4-bit adder slice.

Parameters:
NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 1..16

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op_sub  in  1  0 = A+B, 1 = A-B; latched with start
op_a  in  W  operand A; latched with start
op_b  in  W  operand B; latched with start
busy  out  1  high in RUN
done  out  1  one-cycle pulse; result fields valid from this cycle
result  out  W  A+B or A-B mod 2^W; held until next accepted start
carry_out  out  1  final nibble carry; for subtract, 1 = no borrow (A >= B unsigned)
overflow  out  1  two's-complement overflow of the W-bit operation
adder_a  out  4  nibble of A to slice
adder_b  out  4  nibble of B to slice (slice inverts internally when mode=1)
adder_mode  out  1  slice mode = latched op_sub
adder_cin  out  1  slice carry-in
adder_sum  in  4  slice sum, combinational from adder_* outputs
adder_cout  in  1  slice carry out of bit 3

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - busy, done, carry_out, overflow = 0.
  - result = 0, nibble index = 0, carry register = 0.
  - All adder_* outputs = 0.
- Reset wins over every other input in the same cycle. Reset during RUN aborts the operation: no done pulse, and result is cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches op_a, op_b and op_sub.
  - Sets index = 0 and carry register = op_sub (the +1 of two's-complement subtract).
  - Moves to RUN.
  - start=0 stays in IDLE.
- RUN (busy=1):
  - adder_a = A[4*idx+3:4*idx], adder_b = B[4*idx+3:4*idx], adder_mode = latched op_sub, adder_cin = carry register.
  - Each edge writes adder_sum into result[4*idx+3:4*idx], loads carry register with adder_cout, and increments idx.
  - At the edge where idx == NIBBLES-1: moves to DONE, carry_out <= adder_cout, and overflow is computed from the final nibble.
- Overflow rule:
  - Add: overflow = (a_msb == b_msb) and (sum_msb != a_msb).
  - Subtract: overflow = (a_msb != b_msb) and (sum_msb != a_msb).
  - a_msb and b_msb are bit W-1 of the latched operands (B un-inverted). sum_msb is adder_sum[3] of the final nibble.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then returns to IDLE unconditionally.
  - start asserted while in DONE is ignored, so back-to-back operations need start in a later IDLE cycle.
- Latency:
  - start sampled at edge k; RUN spans the cycles after edges k..k+NIBBLES-1.
  - done is high in the cycle after edge k+NIBBLES.
  - Start-to-done is NIBBLES+1 edges; throughput is one operation per NIBBLES+2 cycles.
- start while busy or done is ignored. Latched operands are unaffected by op_a/op_b/op_sub changes after acceptance.
- Outside RUN, all adder_* outputs are 0 so the slice is free for other users.
- result, carry_out and overflow are held from done until the next accepted start.
  - On acceptance: result clears to 0, and carry_out and overflow clear to 0.
- NIBBLES=1: RUN lasts one cycle; all rules above still apply.

Test Plan:
1. NIBBLES=4, add 0x1234 + 0x0FFF.
   -> busy high 4 cycles; done pulse 5 edges after start; result=0x2233, carry_out=0, overflow=0.
   -> adder_cin sequence 0,1,1,1 (nibble carries) visible on the slice.
2. Add 0xFFFF + 0x0001 -> result=0x0000, carry_out=1, overflow=0.
   Add 0x7FFF + 0x0001 -> result=0x8000, carry_out=0, overflow=1.
3. Subtract 0x0005 - 0x0007 -> adder_mode=1, first adder_cin=1; result=0xFFFE, carry_out=0 (borrow), overflow=0.
   Subtract 0x8000 - 0x0001 -> result=0x7FFF, carry_out=1, overflow=1.
4. Start 0x1111+0x2222, then pulse start again with 0xFFFF/0xFFFF during RUN and during DONE.
   -> both extra starts ignored; result=0x3333; exactly one done pulse.
   -> op_a changed mid-RUN has no effect.
5. Start an add, assert reset for one cycle after the 2nd RUN edge.
   -> no done; result=0, busy=0, adder_* = 0 next cycle.
   -> a new start of 0x0001+0x0001 then yields 0x0002 normally.
6. NIBBLES=1: subtract 0x3 - 0x5 -> result=0xE, carry_out=0, overflow=0; done 2 edges after start.
